// File: rtl/msdap_serial_tx.sv
// Parallel-to-serial word sender for the MSDAP input port: takes L/R word pairs,
// emits them MSB first on InputL/InputR with a Frame pulse on the first bit.
module msdap_serial_tx #(
  parameter int WORD_W = 16,
  parameter int GAP    = 0
) (
  input  logic              DCLK,
  input  logic              Reset_n,
  input  logic              flush,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_l,
  input  logic [WORD_W-1:0] word_r,
  output logic              word_ready,
  input  logic              in_ready,
  output logic              Frame,
  output logic              InputL,
  output logic              InputR,
  output logic              busy,
  output logic [9:0]        word_count
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
  localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [3:0] GAP_LAST = GAP_LAST_I[3:0];
  localparam logic NO_GAP = (GAP == 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic             frame_reg, frame_next;
  logic [9:0]       word_count_reg;
  logic             load, shift_en, count_inc, accept;
  logic [1:0]       sdata;
  logic [WORD_W-1:0] word_in [2];

  assign word_in[0] = word_l;
  assign word_in[1] = word_r;

  // Back-to-back acceptance only exists without a gap: the next word can then
  // start in the cycle right after bit 0.
  assign word_ready = !flush && in_ready &&
                      ((state_reg == ST_IDLE) ||
                       (state_reg == ST_SHIFT && bit_cnt_reg == '0 && NO_GAP));
  assign accept = word_valid && word_ready;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    frame_next   = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    count_inc    = 1'b0;
    if (flush) begin
      state_next   = ST_IDLE;
      bit_cnt_next = BIT_LAST;
      gap_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_next   = ST_SHIFT;
            bit_cnt_next = BIT_LAST;
            frame_next   = 1'b1;
            load         = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_reg != '0) begin
            bit_cnt_next = bit_cnt_reg - CNT_W'(1);
            shift_en     = 1'b1;
          end else begin
            count_inc    = 1'b1;
            bit_cnt_next = BIT_LAST;
            if (accept) begin
              frame_next = 1'b1;
              load       = 1'b1;
            end else if (!NO_GAP) begin
              state_next   = ST_GAP;
              gap_cnt_next = GAP_LAST;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_next   = ST_IDLE;
          bit_cnt_next = BIT_LAST;
        end
      endcase
    end
  end

  always_ff @(posedge DCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= BIT_LAST;
      gap_cnt_reg    <= '0;
      frame_reg      <= 1'b0;
      word_count_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      frame_reg   <= frame_next;
      if (count_inc) begin
        word_count_reg <= word_count_reg + 10'd1;
      end
    end
  end

  // One identical shifter per channel; output bit is registered and forced to 0
  // whenever no bit is being sent (idle, gap, flush).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [WORD_W-1:0] shift_reg;
      logic              sdata_reg;

      always_ff @(posedge DCLK or negedge Reset_n) begin
        if (!Reset_n) begin
          shift_reg <= '0;
          sdata_reg <= 1'b0;
        end else if (load) begin
          sdata_reg <= word_in[gi][WORD_W-1];
          shift_reg <= {word_in[gi][WORD_W-2:0], 1'b0};
        end else if (shift_en) begin
          sdata_reg <= shift_reg[WORD_W-1];
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
        end else begin
          sdata_reg <= 1'b0;
        end
      end

      assign sdata[gi] = sdata_reg;
    end
  endgenerate

  assign Frame      = frame_reg;
  assign InputL     = sdata[0];
  assign InputR     = sdata[1];
  assign busy       = (state_reg != ST_IDLE);
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_msdap_serial_tx.sv
// Directed bench for msdap_serial_tx: one GAP=0 instance and one GAP=4 instance
// on a shared clock, each scenario checked against hand-computed values.
module tb_msdap_serial_tx;

  localparam int W = 16;

  logic DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  logic         Reset_n, flush, in_ready, word_valid0, word_valid4;
  logic [W-1:0] word_l, word_r;
  logic         word_ready0, frame0, input_l0, input_r0, busy0;
  logic [9:0]   word_count0;
  logic         word_ready4, frame4, input_l4, input_r4, busy4;
  logic [9:0]   word_count4;

  int errors = 0;
  int checks = 0;

  msdap_serial_tx #(.WORD_W(W), .GAP(0)) dut0 (
    .DCLK(DCLK), .Reset_n(Reset_n), .flush(flush), .word_valid(word_valid0),
    .word_l(word_l), .word_r(word_r), .word_ready(word_ready0), .in_ready(in_ready),
    .Frame(frame0), .InputL(input_l0), .InputR(input_r0), .busy(busy0),
    .word_count(word_count0)
  );

  msdap_serial_tx #(.WORD_W(W), .GAP(4)) dut4 (
    .DCLK(DCLK), .Reset_n(Reset_n), .flush(flush), .word_valid(word_valid4),
    .word_l(word_l), .word_r(word_r), .word_ready(word_ready4), .in_ready(in_ready),
    .Frame(frame4), .InputL(input_l4), .InputR(input_r4), .busy(busy4),
    .word_count(word_count4)
  );

  task automatic step();
    @(posedge DCLK);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    flush = 1'b0;
    in_ready = 1'b1;
    word_valid0 = 1'b0;
    word_valid4 = 1'b0;
    word_l = '0;
    word_r = '0;
    step();
    step();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] o0, o4;
    do_reset();
    o0 = {frame0, input_l0, input_r0, busy0, 1'b0};
    o4 = {frame4, input_l4, input_r4, busy4, 1'b0};
    checks++;
    if (o0 !== 5'b0 || word_count0 !== 10'd0) begin
      errors++;
      $display("FAIL reset_state0: got outs=%b count=%0d expected outs=00000 count=0", o0, word_count0);
    end
    checks++;
    if (o4 !== 5'b0 || word_count4 !== 10'd0) begin
      errors++;
      $display("FAIL reset_state4: got outs=%b count=%0d expected outs=00000 count=0", o4, word_count4);
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_word();
    logic [15:0] ol, orr, of;
    logic        busy_ok;
    do_reset();
    busy_ok = 1'b1;
    word_valid0 = 1'b1;
    word_l = 16'hA5C3;
    word_r = 16'h0001;
    #1;
    checks++;
    if (word_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 1", word_ready0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) word_valid0 = 1'b0;
      ol[15-i]  = input_l0;
      orr[15-i] = input_r0;
      of[15-i]  = frame0;
      if (busy0 !== 1'b1) busy_ok = 1'b0;
    end
    step();
    checks++;
    if (ol !== 16'hA5C3) begin
      errors++;
      $display("FAIL single_inputl: got %h expected a5c3", ol);
    end
    checks++;
    if (orr !== 16'h0001) begin
      errors++;
      $display("FAIL single_inputr: got %h expected 0001", orr);
    end
    checks++;
    if (of !== 16'h8000) begin
      errors++;
      $display("FAIL single_frame: got %h expected 8000", of);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got low during word expected high");
    end
    checks++;
    if (word_count0 !== 10'd1 || busy0 !== 1'b0 || frame0 !== 1'b0 || input_l0 !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got count=%0d busy=%b frame=%b l=%b expected 1 0 0 0",
               word_count0, busy0, frame0, input_l0);
    end
    $display("test_single_word: word a5c3/0001 sent, count=%0d", word_count0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [47:0] sl, sr, sf;
    logic        busy_ok;
    int          idx;
    words[0] = 16'h1234;
    words[1] = 16'hFFFF;
    words[2] = 16'h8001;
    busy_ok = 1'b1;
    do_reset();
    for (int c = 0; c <= 48; c++) begin
      if (c >= 1) begin
        sl[48-c] = input_l0;
        sr[48-c] = input_r0;
        sf[48-c] = frame0;
        if (busy0 !== 1'b1) busy_ok = 1'b0;
      end
      idx = (c / 16 > 2) ? 2 : c / 16;
      word_valid0 = (c <= 32);
      word_l = words[idx];
      word_r = ~words[idx];
      step();
    end
    checks++;
    if (sl !== 48'h1234_FFFF_8001) begin
      errors++;
      $display("FAIL stream_inputl: got %h expected 1234ffff8001", sl);
    end
    checks++;
    if (sr !== 48'hEDCB_0000_7FFE) begin
      errors++;
      $display("FAIL stream_inputr: got %h expected edcb00007ffe", sr);
    end
    checks++;
    if (sf !== 48'h8000_8000_8000) begin
      errors++;
      $display("FAIL stream_frame: got %h expected 800080008000", sf);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL stream_busy: got low between words expected high");
    end
    checks++;
    if (word_count0 !== 10'd3 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got count=%0d busy=%b expected 3 0", word_count0, busy0);
    end
    $display("test_back_to_back: three words streamed, count=%0d", word_count0);
  endtask

  task automatic test_gap();
    int          f1, f2, nf, gap_ok;
    logic [15:0] gl;
    f1 = -1; f2 = -1; nf = 0; gap_ok = 0;
    do_reset();
    for (int c = 0; c <= 42; c++) begin
      if (frame4 === 1'b1) begin
        if (nf == 0) f1 = c;
        else if (nf == 1) f2 = c;
        nf++;
      end
      if (c >= 1 && c <= 16) gl[16-c] = input_l4;
      if (c >= 17 && c <= 20 && busy4 === 1'b1 && frame4 === 1'b0 &&
          input_l4 === 1'b0 && input_r4 === 1'b0) gap_ok++;
      word_valid4 = (c <= 21);
      word_l = (c <= 20) ? 16'hC001 : 16'h7FFE;
      word_r = 16'hFFFF;
      if (c == 18) begin
        #1;
        checks++;
        if (word_ready4 !== 1'b0) begin
          errors++;
          $display("FAIL gap_ready: got %b expected 0", word_ready4);
        end
      end
      step();
    end
    checks++;
    if (f1 != 1 || f2 != 22 || nf != 2) begin
      errors++;
      $display("FAIL gap_frames: got first=%0d second=%0d n=%0d expected 1 22 2", f1, f2, nf);
    end
    checks++;
    if (gap_ok != 4) begin
      errors++;
      $display("FAIL gap_idle: got %0d good gap cycles expected 4", gap_ok);
    end
    checks++;
    if (gl !== 16'hC001) begin
      errors++;
      $display("FAIL gap_data: got %h expected c001", gl);
    end
    checks++;
    if (word_count4 !== 10'd2 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL gap_end: got count=%0d busy=%b expected 2 0", word_count4, busy4);
    end
    $display("test_gap: frames at %0d and %0d, count=%0d", f1, f2, word_count4);
  endtask

  task automatic test_in_ready();
    logic        blk_ok, gate_ok;
    logic [15:0] il, il2;
    int          fr [2];
    int          nf;
    blk_ok = 1'b1; gate_ok = 1'b1; nf = 0;
    fr[0] = -1; fr[1] = -1;
    do_reset();
    in_ready = 1'b0;
    word_valid0 = 1'b1;
    word_l = 16'h0F0F;
    word_r = 16'h3C3C;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (word_ready0 !== 1'b0) blk_ok = 1'b0;
      step();
      if (frame0 !== 1'b0 || busy0 !== 1'b0) blk_ok = 1'b0;
    end
    checks++;
    if (blk_ok !== 1'b1) begin
      errors++;
      $display("FAIL inready_block: got ready/frame while in_ready=0 expected none");
    end
    for (int c = 0; c <= 39; c++) begin
      if (frame0 === 1'b1) begin
        if (nf < 2) fr[nf] = c;
        nf++;
      end
      if (c >= 1 && c <= 16) il[16-c] = input_l0;
      if (c >= 24) il2[39-c] = input_l0;
      in_ready = (c < 8) || (c >= 23);
      word_valid0 = (c <= 23);
      word_l = (c == 0) ? 16'h0F0F : 16'hF0F0;
      if (c >= 17 && c <= 22) begin
        #1;
        if (word_ready0 !== 1'b0) gate_ok = 1'b0;
      end
      step();
    end
    checks++;
    if (il !== 16'h0F0F) begin
      errors++;
      $display("FAIL inready_word1: got %h expected 0f0f", il);
    end
    checks++;
    if (il2 !== 16'hF0F0) begin
      errors++;
      $display("FAIL inready_word2: got %h expected f0f0", il2);
    end
    checks++;
    if (fr[0] != 1 || fr[1] != 24 || nf != 2 || gate_ok !== 1'b1) begin
      errors++;
      $display("FAIL inready_frames: got %0d %0d n=%0d gate=%b expected 1 24 2 1",
               fr[0], fr[1], nf, gate_ok);
    end
    checks++;
    if (word_count0 !== 10'd2) begin
      errors++;
      $display("FAIL inready_count: got %0d expected 2", word_count0);
    end
    $display("test_in_ready: frames at %0d and %0d, count=%0d", fr[0], fr[1], word_count0);
  endtask

  task automatic test_flush();
    do_reset();
    word_l = 16'hFFFF;
    word_r = 16'hFFFF;
    for (int c = 0; c <= 30; c++) begin
      if (c == 11) begin
        checks++;
        if (input_l0 !== 1'b1 || input_r0 !== 1'b1 || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL flush_pre: got l=%b r=%b busy=%b expected 1 1 1", input_l0, input_r0, busy0);
        end
      end
      if (c == 12) begin
        checks++;
        if (frame0 !== 1'b0 || input_l0 !== 1'b0 || input_r0 !== 1'b0 || busy0 !== 1'b0 ||
            word_count0 !== 10'd0) begin
          errors++;
          $display("FAIL flush_abort: got f=%b l=%b r=%b busy=%b count=%0d expected 0 0 0 0 0",
                   frame0, input_l0, input_r0, busy0, word_count0);
        end
      end
      if (c == 13) begin
        checks++;
        if (frame0 !== 1'b0 || busy0 !== 1'b0) begin
          errors++;
          $display("FAIL flush_priority: got frame=%b busy=%b expected 0 0", frame0, busy0);
        end
      end
      if (c == 14) begin
        checks++;
        if (frame0 !== 1'b1) begin
          errors++;
          $display("FAIL flush_restart: got frame=%b expected 1", frame0);
        end
      end
      word_valid0 = (c == 0) || (c == 12) || (c == 13);
      flush = (c == 11) || (c == 12);
      if (c == 12) begin
        #1;
        checks++;
        if (word_ready0 !== 1'b0) begin
          errors++;
          $display("FAIL flush_ready: got %b expected 0", word_ready0);
        end
      end
      step();
    end
    checks++;
    if (word_count0 !== 10'd1) begin
      errors++;
      $display("FAIL flush_count: got %0d expected 1", word_count0);
    end
    $display("test_flush: aborted word dropped, count=%0d", word_count0);
  endtask

  task automatic test_async_reset();
    do_reset();
    word_l = 16'hFFFF;
    word_r = 16'hFFFF;
    for (int c = 0; c <= 21; c++) begin
      word_valid0 = (c == 0) || (c == 17);
      step();
    end
    checks++;
    if (input_l0 !== 1'b1 || busy0 !== 1'b1 || word_count0 !== 10'd1) begin
      errors++;
      $display("FAIL areset_pre: got l=%b busy=%b count=%0d expected 1 1 1", input_l0, busy0, word_count0);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (frame0 !== 1'b0 || input_l0 !== 1'b0 || input_r0 !== 1'b0 || busy0 !== 1'b0 ||
        word_count0 !== 10'd0) begin
      errors++;
      $display("FAIL areset_now: got f=%b l=%b r=%b busy=%b count=%0d expected 0 0 0 0 0",
               frame0, input_l0, input_r0, busy0, word_count0);
    end
    step();
    step();
    Reset_n = 1'b1;
    word_valid0 = 1'b1;
    word_l = 16'h8001;
    word_r = 16'h0000;
    step();
    word_valid0 = 1'b0;
    checks++;
    if (frame0 !== 1'b1 || input_l0 !== 1'b1 || input_r0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL areset_fresh: got f=%b l=%b r=%b busy=%b expected 1 1 0 1",
               frame0, input_l0, input_r0, busy0);
    end
    $display("test_async_reset: mid-word reset cleared outputs");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c <= 16 * 1024; c++) begin
      if (c == 16 * 1023 + 1) begin
        checks++;
        if (word_count0 !== 10'd1023) begin
          errors++;
          $display("FAIL wrap_1023: got %0d expected 1023", word_count0);
        end
      end
      word_valid0 = (c <= 16 * 1023);
      word_l = c[15:0];
      word_r = ~c[15:0];
      step();
    end
    checks++;
    if (word_count0 !== 10'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero: got count=%0d busy=%b expected 0 0", word_count0, busy0);
    end
    $display("test_wrap: 1024 words sent, count=%0d", word_count0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_in_ready();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
